// File: rtl/duty_step_ctrl.sv
// duty_step_ctrl: button front end for the PWM generator.
// Two raw buttons are synchronised (2 flops) and debounced. A press/hold FSM then turns
// debounced presses into saturating steps of the duty register that feeds the PWM comparator.
// Simultaneous presses lock the FSM out until both buttons are released.
// Optional feature: define DUTY_STEP_AUTO_REPEAT_EN to get auto-repeat steps while a button
// is held (first repeat REPEAT_DELAY cycles after the press step, then every REPEAT_RATE).
module duty_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_RATE     = 8,
  parameter int unsigned DUTY_W          = 4,
  parameter int unsigned DUTY_MAX        = 10,
  parameter int unsigned DUTY_INIT       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_inc,
  input  logic              btn_dec,
  output logic [DUTY_W-1:0] duty_out,
  output logic              inc_pulse,
  output logic              dec_pulse,
  output logic              at_max,
  output logic              at_min
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DUTY_W-1:0] DutyMax  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DutyInit = DUTY_W'(DUTY_INIT);

`ifdef DUTY_STEP_AUTO_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  logic [RepW-1:0] rep_cnt_q;
`endif

  typedef enum logic [1:0] {StIdle, StHoldInc, StHoldDec, StLockout} state_e;

  // Bit 0 tracks the increment button, bit 1 the decrement button.
  logic [1:0]     sync1_q, sync2_q, deb_q;
  logic [DbW-1:0] db_cnt_q [2];
  state_e         state_q;
  logic [DUTY_W-1:0] duty_q;
  logic           inc_pulse_q, dec_pulse_q;
  logic           req_inc, req_dec, do_inc, do_dec;

  // Two-flop synchroniser for both raw buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btn_dec, btn_inc};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: level flips only after the synced input disagrees for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q       <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          deb_q[i]    <= ~deb_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Step requests from the FSM, then gated by saturation.
  always_comb begin
    req_inc = 1'b0;
    req_dec = 1'b0;
    case (state_q)
      StIdle: begin
        if (deb_q == 2'b01) req_inc = 1'b1;
        else if (deb_q == 2'b10) req_dec = 1'b1;
      end
`ifdef DUTY_STEP_AUTO_REPEAT_EN
      StHoldInc: begin
        if (deb_q == 2'b01 && rep_cnt_q == RepW'(1)) req_inc = 1'b1;
      end
      StHoldDec: begin
        if (deb_q == 2'b10 && rep_cnt_q == RepW'(1)) req_dec = 1'b1;
      end
`endif
      default: ;
    endcase
    do_inc = req_inc && (duty_q < DutyMax);
    do_dec = req_dec && (duty_q != '0);
  end

  // Press/hold FSM with the duty register and registered step pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      duty_q      <= DutyInit;
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
`ifdef DUTY_STEP_AUTO_REPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      inc_pulse_q <= do_inc;
      dec_pulse_q <= do_dec;
      if (do_inc)      duty_q <= duty_q + DUTY_W'(1);
      else if (do_dec) duty_q <= duty_q - DUTY_W'(1);

      case (state_q)
        StIdle: begin
          if (deb_q == 2'b11) begin
            state_q <= StLockout;
          end else if (deb_q == 2'b01) begin
            state_q <= StHoldInc;
`ifdef DUTY_STEP_AUTO_REPEAT_EN
            rep_cnt_q <= RepW'(REPEAT_DELAY);
`endif
          end else if (deb_q == 2'b10) begin
            state_q <= StHoldDec;
`ifdef DUTY_STEP_AUTO_REPEAT_EN
            rep_cnt_q <= RepW'(REPEAT_DELAY);
`endif
          end
        end
        StHoldInc: begin
          if (!deb_q[0]) begin
            state_q <= StIdle;
          end else if (deb_q[1]) begin
            state_q <= StLockout;
          end
`ifdef DUTY_STEP_AUTO_REPEAT_EN
          else if (rep_cnt_q == RepW'(1)) begin
            rep_cnt_q <= RepW'(REPEAT_RATE);
          end else begin
            rep_cnt_q <= rep_cnt_q - RepW'(1);
          end
`endif
        end
        StHoldDec: begin
          if (!deb_q[1]) begin
            state_q <= StIdle;
          end else if (deb_q[0]) begin
            state_q <= StLockout;
          end
`ifdef DUTY_STEP_AUTO_REPEAT_EN
          else if (rep_cnt_q == RepW'(1)) begin
            rep_cnt_q <= RepW'(REPEAT_RATE);
          end else begin
            rep_cnt_q <= rep_cnt_q - RepW'(1);
          end
`endif
        end
        StLockout: begin
          if (deb_q == 2'b00) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign duty_out  = duty_q;
  assign inc_pulse = inc_pulse_q;
  assign dec_pulse = dec_pulse_q;
  assign at_max    = (duty_q == DutyMax);
  assign at_min    = (duty_q == '0);

endmodule

// File: tb/tb_duty_step_ctrl.sv
// Bench for duty_step_ctrl (default parameters). Expected step pulses are queued when a
// press is driven and matched against observed pulses by a monitor.
module tb_duty_step_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [3:0] duty_out;
  logic       inc_pulse, dec_pulse, at_max, at_min;

  duty_step_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .duty_out (duty_out),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse),
    .at_max   (at_max),
    .at_min   (at_min)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned edge_no;
    logic        is_inc;
    logic [3:0]  duty;
  } exp_t;

  typedef struct {
    string      name;
    logic       inc;
    logic       dec;
    int         hold;
    int         gap;
    logic       step;
    logic [3:0] duty_after;
  } vec_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge right when the press is driven: off counts edges from the last one.
  task automatic expect_step(input logic is_inc, input int unsigned off, input logic [3:0] d);
    exp_t e;
    e.edge_no = cyc + off;
    e.is_inc  = is_inc;
    e.duty    = d;
    sb_q.push_back(e);
  endtask

  // Pulse monitor, sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !rst) begin
        while (sb_q.size() > 0 && sb_q[0].edge_no < cyc) begin
          n_cmp++;
          n_fail++;
          $display("FAIL missed_pulse: pulse expected at edge %0d did not occur (now %0d)",
                   sb_q[0].edge_no, cyc);
          void'(sb_q.pop_front());
        end
        if (inc_pulse === 1'b1 && dec_pulse === 1'b1) check("both_pulses", 32'd1, 32'd0);
        if (inc_pulse !== 1'b0 || dec_pulse !== 1'b0) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_pulse: inc=%b dec=%b at edge %0d, expected no pulse",
                     inc_pulse, dec_pulse, cyc);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("pulse_edge", cyc, e.edge_no);
            check("pulse_kind_inc", {31'd0, inc_pulse}, {31'd0, e.is_inc});
            check("pulse_kind_dec", {31'd0, dec_pulse}, {31'd0, ~e.is_inc});
            check("pulse_duty", {28'd0, duty_out}, {28'd0, e.duty});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef DUTY_STEP_AUTO_REPEAT_EN
  localparam int NRep = 5;
`else
  localparam int NRep = 1;
`endif

  vec_t        vecs[12];
  logic [3:0]  d_now;
  int unsigned c0;

  initial begin
    vecs[0]  = '{"glitch_inc",  1'b1, 1'b0, 3,  10, 1'b0, 4'd5};
    vecs[1]  = '{"inc_to_6",    1'b1, 1'b0, 12, 10, 1'b1, 4'd6};
    vecs[2]  = '{"inc_to_7",    1'b1, 1'b0, 10, 10, 1'b1, 4'd7};
    vecs[3]  = '{"inc_to_8",    1'b1, 1'b0, 10, 10, 1'b1, 4'd8};
    vecs[4]  = '{"inc_to_9",    1'b1, 1'b0, 10, 10, 1'b1, 4'd9};
    vecs[5]  = '{"inc_to_10",   1'b1, 1'b0, 10, 10, 1'b1, 4'd10};
    vecs[6]  = '{"inc_sat_a",   1'b1, 1'b0, 10, 10, 1'b0, 4'd10};
    vecs[7]  = '{"inc_sat_b",   1'b1, 1'b0, 10, 10, 1'b0, 4'd10};
    vecs[8]  = '{"dec_to_9",    1'b0, 1'b1, 10, 10, 1'b1, 4'd9};
    vecs[9]  = '{"dec_to_8",    1'b0, 1'b1, 10, 10, 1'b1, 4'd8};
    vecs[10] = '{"glitch_dec",  1'b0, 1'b1, 2,  10, 1'b0, 4'd8};
    vecs[11] = '{"dec_to_7",    1'b0, 1'b1, 10, 10, 1'b1, 4'd7};

    // Reset state.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst_duty", {28'd0, duty_out}, 32'd5);
    check("rst_inc_pulse", {31'd0, inc_pulse}, 32'd0);
    check("rst_dec_pulse", {31'd0, dec_pulse}, 32'd0);
    check("rst_at_max", {31'd0, at_max}, 32'd0);
    check("rst_at_min", {31'd0, at_min}, 32'd0);
    mon_en = 1'b1;

    // Single presses, glitches and saturation at the top.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].step) expect_step(vecs[i].inc, 7, vecs[i].duty_after);
      btn_inc = vecs[i].inc;
      btn_dec = vecs[i].dec;
      tick(vecs[i].hold);
      btn_inc = 1'b0;
      btn_dec = 1'b0;
      tick(vecs[i].gap);
      check({vecs[i].name, "_duty"}, {28'd0, duty_out}, {28'd0, vecs[i].duty_after});
      check({vecs[i].name, "_at_max"}, {31'd0, at_max}, {31'd0, vecs[i].duty_after == 4'd10});
      check({vecs[i].name, "_at_min"}, {31'd0, at_min}, {31'd0, vecs[i].duty_after == 4'd0});
      check({vecs[i].name, "_pending"}, sb_q.size(), 32'd0);
    end

    // Both buttons together lock out; releasing one keeps the lockout.
    btn_inc = 1'b1;
    btn_dec = 1'b1;
    tick(20);
    btn_inc = 1'b0;
    tick(20);
    btn_dec = 1'b0;
    tick(10);
    check("lockout_duty", {28'd0, duty_out}, 32'd7);
    expect_step(1'b0, 7, 4'd6);
    btn_dec = 1'b1;
    tick(10);
    btn_dec = 1'b0;
    tick(10);
    check("post_lockout_duty", {28'd0, duty_out}, 32'd6);
    check("post_lockout_pending", sb_q.size(), 32'd0);

    // Held decrement from 5: auto-repeat runs down to 0 and saturates.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst2_duty", {28'd0, duty_out}, 32'd5);
    for (int k = 0; k < NRep; k++) begin
      expect_step(1'b0, (k == 0) ? 7 : 23 + 8 * (k - 1), 4'(4 - k));
    end
    btn_dec = 1'b1;
    tick(60);
    btn_dec = 1'b0;
    tick(10);
    check("hold_dec_duty", {28'd0, duty_out}, 32'(5 - NRep));
    check("hold_dec_at_min", {31'd0, at_min}, {31'd0, NRep == 5});
    check("hold_dec_pending", sb_q.size(), 32'd0);

    // Reset while a button is held: the held button counts as a fresh press afterwards.
    d_now = duty_out;
    c0 = cyc;
    expect_step(1'b1, 7, d_now + 4'd1);
    btn_inc = 1'b1;
    tick(19);
    rst = 1'b1;
    tick(1);
    check("midrst_edge", cyc - c0, 32'd20);
    check("midrst_duty", {28'd0, duty_out}, 32'd5);
    check("midrst_inc_pulse", {31'd0, inc_pulse}, 32'd0);
    rst = 1'b0;
    expect_step(1'b1, 7, 4'd6);
    tick(15);
    btn_inc = 1'b0;
    tick(10);
    check("after_midrst_duty", {28'd0, duty_out}, 32'd6);
    check("final_pending", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
